rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port a_valid, input, 1, requester A (pipeline writeback) has a write pending.
REQ-004 SHALL have port a_ready, output, 1, requester A write accepted this cycle.
REQ-005 SHALL have port a_wsel, input, 5, requester A destination register.
REQ-006 SHALL have port a_wdat, input, 32, requester A write data.
REQ-007 SHALL have ports b_valid, b_ready, b_wsel and b_wdat with the same directions, widths and meanings for requester B (long-latency unit).
REQ-008 SHALL have port flush, input, 1, suppresses acceptance this cycle and cancels the staged write.
REQ-009 SHALL have port WEN, output, 1, register file write enable; registered.
REQ-010 SHALL have port wsel, output, 5, register file write select; registered.
REQ-011 SHALL have port wdat, output, 32, register file write data; registered.
REQ-012 SHALL have port busy, output, 1, high when WEN is high or any requester is valid.

Function
REQ-013 SHALL accept at most one write per cycle; accepted means valid and ready both high in the same cycle.
REQ-014 SHALL compute a_ready and b_ready combinationally from the valids, the priority pointer and flush; ready SHALL NOT depend on any data or select input.
REQ-015 SHALL grant a lone valid requester in the same cycle, regardless of the pointer.
REQ-016 SHALL resolve simultaneous requests round-robin with a 1-bit pointer: ptr=0 grants A, ptr=1 grants B.
REQ-017 SHALL set ptr to 1 after each A grant and to 0 after each B grant, and SHALL leave ptr unchanged in cycles with no grant.
REQ-018 SHALL, on a grant, load wsel and wdat from the granted requester and drive WEN high for exactly the following cycle (latency 1).
REQ-019 SHALL accept and consume a write to register 0 (ready high, ptr updated) while keeping WEN low in the following cycle.
REQ-020 SHALL drive WEN low, and hold wsel and wdat at their last values, in any cycle that follows a cycle with no grant.
REQ-021 SHALL, while flush is high, hold a_ready and b_ready low, leave ptr unchanged and drive WEN low in the next cycle.
REQ-022 SHALL NOT cancel a write already presented on WEN when flush is raised.
REQ-023 SHALL write same-register requests from A and B in grant order, so the later-granted data is the final register value.
REQ-024 SHALL allow the losing requester to hold valid with stable data; the loser SHALL be granted in the next cycle under round-robin.

Reset
REQ-025 SHALL, while nRST is low, force WEN=0, wsel=0, wdat=0 and ptr=0.
REQ-026 SHALL drive a_ready=0 and b_ready=0 while nRST is low.
REQ-027 SHALL discard a staged write if reset asserts mid-operation; that write SHALL NOT appear after reset release.

Configuration
REQ-028 SHALL support macro RF_ARB_FIXED_PRIO_EN.
REQ-029 SHALL, when RF_ARB_FIXED_PRIO_EN is defined, always grant A over B on a conflict and ignore ptr.
REQ-030 SHALL, when RF_ARB_FIXED_PRIO_EN is undefined, use the round-robin behaviour of REQ-016 and REQ-017.

Verification
REQ-031 SHALL cover: A only, a_wsel=5, a_wdat=0xDEADBEEF -> a_ready=1 that cycle; next cycle WEN=1, wsel=5, wdat=0xDEADBEEF.
REQ-032 SHALL cover: A and B valid for 4 cycles from reset (A: sel 3 / 0x11, B: sel 4 / 0x22) -> grants A,B,A,B; WEN pulses on sel 3,4,3,4; with RF_ARB_FIXED_PRIO_EN defined -> grants A,A,A,A.
REQ-033 SHALL cover: B only, b_wsel=0, b_wdat=0xFFFFFFFF -> b_ready=1; next cycle WEN=0; ptr=0 afterwards.
REQ-034 SHALL cover: flush=1 with both valid -> both ready=0; next cycle WEN=0; ptr unchanged.
REQ-035 SHALL cover: A and B both target sel 7 (A 0x1, B 0x2) with ptr=0 -> WEN on sel 7 with 0x1, then with 0x2; final value 0x2.
REQ-036 SHALL cover: nRST asserted in the cycle after a grant -> WEN=0, wsel=0, wdat=0 immediately; no WEN pulse after reset release.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write-port arbiter.
// Requester A (pipeline writeback) and B (long-latency unit) compete for a
// single registered write port. Conflicts are resolved round-robin by a
// one-bit priority pointer; a lone requester is granted immediately.
// Writes to register 0 are accepted and consumed but never raise WEN.
// Optional build macro: RF_ARB_FIXED_PRIO_EN -- A always beats B on a conflict.
module rf_write_arbiter (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_wsel,
    input  logic [31:0] a_wdat,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_wsel,
    input  logic [31:0] b_wdat,
    input  logic        flush,
    output logic        WEN,
    output logic [4:0]  wsel,
    output logic [31:0] wdat,
    output logic        busy
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e       ptr_q, ptr_d;
    logic        wen_q, wen_d;
    logic [4:0]  wsel_q, wsel_d;
    logic [31:0] wdat_q, wdat_d;
    logic        a_wins;
    logic        grant_a;
    logic        grant_b;

    // Grant decision: depends only on valids, pointer, flush and reset.
    always_comb begin
`ifdef RF_ARB_FIXED_PRIO_EN
        a_wins  = 1'b1;
`else
        a_wins  = (ptr_q == PRIO_A);
`endif
        grant_a = nRST && !flush && a_valid && (!b_valid ||  a_wins);
        grant_b = nRST && !flush && b_valid && (!a_valid || !a_wins);
    end

    // Next-state for pointer and the registered write port.
    always_comb begin
        ptr_d  = ptr_q;
        wen_d  = 1'b0;
        wsel_d = wsel_q;
        wdat_d = wdat_q;
        if (grant_a) begin
            ptr_d  = PRIO_B;
            wen_d  = (a_wsel != 5'd0);
            wsel_d = a_wsel;
            wdat_d = a_wdat;
        end else if (grant_b) begin
            ptr_d  = PRIO_A;
            wen_d  = (b_wsel != 5'd0);
            wsel_d = b_wsel;
            wdat_d = b_wdat;
        end
    end

    // State registers; reset drops any staged write immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q  <= PRIO_A;
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            wsel_q <= wsel_d;
            wdat_q <= wdat_d;
        end
    end

    // Output drive.
    always_comb begin
        a_ready = grant_a;
        b_ready = grant_b;
        WEN     = wen_q;
        wsel    = wsel_q;
        wdat    = wdat_q;
        busy    = wen_q | a_valid | b_valid;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_rf_write_arbiter;

`ifdef RF_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0, flush = 1'b0;
    logic [4:0]  a_wsel = '0, b_wsel = '0;
    logic [31:0] a_wdat = '0, b_wdat = '0;
    logic        a_ready, b_ready, WEN, busy;
    logic [4:0]  wsel;
    logic [31:0] wdat;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // Reference model state
    bit          m_ptr;      // 0: A favoured on conflict, 1: B favoured
    bit          m_wen;
    bit [4:0]    m_sel;
    bit [31:0]   m_dat;
    bit          m_known;    // wsel/wdat expectation is meaningful
    bit          obs_a, obs_b;
    logic [31:0] rf [32];    // register file built from observed writes

    rf_write_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .a_valid(a_valid), .a_ready(a_ready), .a_wsel(a_wsel), .a_wdat(a_wdat),
        .b_valid(b_valid), .b_ready(b_ready), .b_wsel(b_wsel), .b_wdat(b_wdat),
        .flush(flush), .WEN(WEN), .wsel(wsel), .wdat(wdat), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 1'b0; m_wen = 1'b0; m_sel = '0; m_dat = '0; m_known = 1'b1;
    endtask

    // Hold reset for one cycle with both requesters valid; release at negedge.
    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0; a_valid = 1'b1; b_valid = 1'b1; flush = 1'b0;
        #1;
        check_eq("rst_a_ready", a_ready, 1'b0);
        check_eq("rst_b_ready", b_ready, 1'b0);
        check_eq("rst_WEN", WEN, 1'b0);
        check_eq("rst_wsel", wsel, 32'd0);
        check_eq("rst_wdat", wdat, 32'd0);
        model_reset();
        @(negedge CLK);
        a_valid = 1'b0; b_valid = 1'b0;
        nRST = 1'b1;
    endtask

    // One cycle: drive at negedge, check readies, then check write port after posedge.
    task automatic step(input logic av, input logic [4:0] as, input logic [31:0] ad,
                        input logic bv, input logic [4:0] bs, input logic [31:0] bd,
                        input logic fl);
        bit ea, eb;
        @(negedge CLK);
        a_valid = av; a_wsel = as; a_wdat = ad;
        b_valid = bv; b_wsel = bs; b_wdat = bd;
        flush = fl;
        #1;
        ea = 1'b0; eb = 1'b0;
        if (!fl) begin
            if (av && !bv)      ea = 1'b1;
            else if (bv && !av) eb = 1'b1;
            else if (av && bv) begin
                if (FIXED || !m_ptr) ea = 1'b1;
                else                 eb = 1'b1;
            end
        end
        obs_a = a_ready; obs_b = b_ready;
        check_eq("a_ready", a_ready, ea);
        check_eq("b_ready", b_ready, eb);
        check_eq("busy", busy, m_wen | av | bv);
        @(posedge CLK);
        #1;
        if (ea) begin
            m_ptr = 1'b1; m_wen = (as != 0); m_sel = as; m_dat = ad; m_known = (as != 0);
        end else if (eb) begin
            m_ptr = 1'b0; m_wen = (bs != 0); m_sel = bs; m_dat = bd; m_known = (bs != 0);
        end else begin
            m_wen = 1'b0;
        end
        check_eq("WEN", WEN, m_wen);
        if (m_known) begin
            check_eq("wsel", wsel, m_sel);
            check_eq("wdat", wdat, m_dat);
        end
        if (WEN === 1'b1) rf[wsel] = wdat;
    endtask

    initial begin
        bit [3:0] rr_exp;
        model_reset();
        repeat (2) @(posedge CLK);
        do_reset();

        // Lone A write
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("lone_a_WEN", WEN, 1'b1);
        check_eq("lone_a_wsel", wsel, 32'd5);
        check_eq("lone_a_wdat", wdat, 32'hDEADBEEF);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("hold_wsel", wsel, 32'd5);
        check_eq("hold_wdat", wdat, 32'hDEADBEEF);

        // Conflict for four cycles from reset
        do_reset();
        rr_exp = FIXED ? 4'b1111 : 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
            check_eq("rr_grant_a", obs_a, rr_exp[i]);
            check_eq("rr_sel", wsel, rr_exp[i] ? 32'd3 : 32'd4);
        end

        // Lone B write to register 0: consumed, no WEN, pointer back to A
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        check_eq("r0_b_ready", obs_b, 1'b1);
        check_eq("r0_WEN", WEN, 1'b0);
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0);
        check_eq("r0_ptr_a", obs_a, 1'b1);

        // Flush with both valid: no grant, pointer unchanged (still favours B)
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b1);
        check_eq("flush_a", obs_a, 1'b0);
        check_eq("flush_b", obs_b, 1'b0);
        check_eq("flush_WEN", WEN, 1'b0);
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0);
        check_eq("post_flush_b", obs_b, FIXED ? 1'b0 : 1'b1);

        // Flush raised while a write is on WEN does not cancel it
        step(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge CLK);
        flush = 1'b1;
        #1;
        check_eq("flush_keep_WEN", WEN, 1'b1);
        flush = 1'b0;

        // Same register from both: grant order decides final value
        do_reset();
        rf[7] = 32'd0;
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0);
        check_eq("same_first", wdat, 32'h1);
        step(FIXED ? 1'b0 : 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0);
        check_eq("same_second", wdat, 32'h2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("same_final", rf[7], 32'h2);

        // Reset asserted in the cycle after a grant
        step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("pre_rst_WEN", WEN, 1'b1);
        #2;
        nRST = 1'b0;
        a_valid = 1'b1;
        #1;
        check_eq("async_WEN", WEN, 1'b0);
        check_eq("async_wsel", wsel, 32'd0);
        check_eq("async_wdat", wdat, 32'd0);
        check_eq("async_a_ready", a_ready, 1'b0);
        model_reset();
        @(negedge CLK);
        a_valid = 1'b0;
        nRST = 1'b1;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("post_rst_WEN", WEN, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
